serial_rx_fifo_n: RTL and testbench
===================================

# serial_rx_fifo_n

Multi-lane serial receiver with per-lane word alignment and buffering. It is the parametrised successor of the two-lane serial-to-parallel/FIFO device, generalised in lane count, word width, FIFO depth, comma value and sync threshold. Each lane deserialises MSB-first, hunts for the comma word, declares itself active after SYNC_COUNT aligned commas, and pushes every non-comma word into its own FIFO. The FIFO is drained by a downstream consumer. Added over the previous generation: bit-level comma hunting, a sticky overflow flag, and a per-lane active status.

## Interface
- LANES, 2, number of independent serial lanes
- WORD_W, 8, deserialised word width in bits
- DEPTH, 4, FIFO entries per lane; power of two, ≥2
- AF_THRESH, 3, almost_full asserts when occupancy ≥ AF_THRESH (1..DEPTH)
- COMMA, 8'hBC, alignment/idle word (WORD_W bits)
- SYNC_COUNT, 4, consecutive aligned commas required to go active
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low; 0 clears everything
- in  in  LANES  serial data bit per lane, sampled every clk edge
- read  in  LANES  per-lane pop request
- out  out  LANES*WORD_W  popped word, lane i at [i*WORD_W +: WORD_W]
- valid_out  out  LANES  1-cycle strobe: out lane i holds a freshly popped word
- empty  out  LANES  lane FIFO empty
- almost_full  out  LANES  lane occupancy ≥ AF_THRESH
- active  out  LANES  lane has achieved sync
- overflow  out  LANES  sticky: a word was dropped because the FIFO was full

## Operation
- Reset values: out=0, valid_out=0, empty=all 1, almost_full=0, active=0, overflow=0. All FSMs return to SEARCH, and the counters and pointers go to 0.
- Shift register per lane: shreg <= {shreg[WORD_W-2:0], in[i]} every cycle.
- Lane FSM:
  - SEARCH: compare the next shreg value with COMMA every cycle. On a match, go to ALIGN, set bc_cnt=1 and bit_cnt=0; word boundaries now fall every WORD_W cycles.
  - ALIGN: at each boundary, a COMMA increments bc_cnt. When bc_cnt reaches SYNC_COUNT, go to ACTIVE. Any non-comma word returns the lane to SEARCH with bc_cnt=0.
  - SYNC_COUNT=1 means the first match goes directly to ACTIVE.
  - ACTIVE: at each boundary, a COMMA word is discarded as idle; any other word is written to the lane FIFO. ACTIVE is left only by reset.
- active[i] = (state==ACTIVE), registered.
- FIFO: pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- Write when full:
  - read also asserted in the same cycle: both occur and count is unchanged.
  - no read in that cycle: the word is dropped and overflow[i] is set until reset.
- Read when empty: ignored; valid_out stays 0 and out holds its previous value.
- Lanes are fully independent; a simultaneous event on multiple lanes has no interaction.
- Reset mid-word or mid-FIFO: all partial words and stored data are lost, and the lane restarts in SEARCH.

## Timing
- Comma detection in SEARCH: the edge that samples the last comma bit moves the FSM to ALIGN.
- A word's last bit sampled at edge k is written to the FIFO at edge k+1. empty/almost_full reflect the write after edge k+1.
- read sampled high at edge m with !empty: out and valid_out update at edge m, and valid_out drops at m+1 unless read is held. Back-to-back reads pop one word per cycle.
- The earliest active assertion after reset release is SYNC_COUNT*WORD_W cycles after the first comma bit.
- empty/almost_full are registered outputs with the same-edge count update (no extra lag).

## Structure
- Package serial_rx_pkg holds:
  - the lane state enum (SEARCH, ALIGN, ACTIVE)
  - default COMMA and SYNC_COUNT constants
  - a clog2-based pointer-width helper
- Sub-module serial_lane_rx contains shreg, bit_cnt, bc_cnt, the FSM and the FIFO for one lane. The top level instantiates LANES copies via generate and concatenates their outputs.

## Test plan
- Reset held low with toggling in; then 01010101 pattern on both lanes -> active=00 and empty=11 throughout; all outputs remain at their reset values.
- Lane 0 receives 4×BC then FF, DD; lane 1 stays idle -> active=01 after the 4th BC; lane 0 FIFO holds FF then DD; read pops FF and then DD with valid_out pulses; the lane 1 FIFO remains empty.
- Comma offset by 3 bits, 3×BC then 55 -> lane returns to SEARCH, active stays 0; re-sending 4×BC yields active=1.
- DEPTH=4: write 5 non-comma words (11,22,33,44,55) without reading -> almost_full=1 after 3 words, 55 is dropped, overflow=1; reads return 11,22,33,44, then empty=1.
- FIFO full while a write coincides with a read -> no overflow, occupancy stays 4, order is preserved.
- Reset asserted mid-word while ACTIVE with 2 entries stored -> empty=1, active=0, overflow=0, out=0 immediately (asynchronous).

Source files
------------

// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the multi-lane serial receiver.
package serial_rx_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } lane_state_t;

  localparam logic [7:0] DEFAULT_COMMA      = 8'hBC;
  localparam int         DEFAULT_SYNC_COUNT = 4;

  // Bits needed to index 'depth' items; never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/serial_lane_rx.sv
// One receive lane: MSB-first deserialiser, comma hunt/alignment FSM and
// a small word FIFO drained by the downstream consumer.
module serial_lane_rx
  import serial_rx_pkg::*;
#(
  parameter int                WORD_W     = 8,
  parameter int                DEPTH      = 4,
  parameter int                AF_THRESH  = 3,
  parameter logic [WORD_W-1:0] COMMA      = WORD_W'(DEFAULT_COMMA),
  parameter int                SYNC_COUNT = DEFAULT_SYNC_COUNT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in,
  input  logic              read,
  output logic [WORD_W-1:0] out,
  output logic              valid_out,
  output logic              empty,
  output logic              almost_full,
  output logic              active,
  output logic              overflow
);

  localparam int BIT_W = ptr_width(WORD_W);
  localparam int BC_W  = ptr_width(SYNC_COUNT + 1);
  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);
  localparam logic [BC_W-1:0]  BC_DONE  = BC_W'(SYNC_COUNT);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_THRESH);

  lane_state_t        state;
  // Only the older WORD_W-1 bits are stored; the newest bit is 'in' itself.
  logic [WORD_W-2:0]  shreg;
  logic [WORD_W-1:0]  word_nxt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [BC_W-1:0]    bc_cnt;
  logic               is_comma;
  logic               boundary;

  logic               wr_vld_p1;
  logic [WORD_W-1:0]  wr_data_p1;

  logic [WORD_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_nxt;
  logic               full;
  logic               rd_en;
  logic               wr_en;

  assign word_nxt = {shreg, in};
  assign is_comma = (word_nxt == COMMA);
  assign boundary = (bit_cnt == LAST_BIT);

  // Deserialiser plus SEARCH/ALIGN/ACTIVE alignment FSM with registered status.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SEARCH;
      shreg     <= '0;
      bit_cnt   <= '0;
      bc_cnt    <= '0;
      active    <= 1'b0;
      wr_vld_p1 <= 1'b0;
    end else begin
      shreg     <= word_nxt[WORD_W-2:0];
      wr_vld_p1 <= 1'b0;
      case (state)
        SEARCH: begin
          if (is_comma) begin
            bit_cnt <= '0;
            bc_cnt  <= BC_W'(1);
            if (SYNC_COUNT == 1) begin
              state  <= ACTIVE;
              active <= 1'b1;
            end else begin
              state <= ALIGN;
            end
          end
        end
        ALIGN: begin
          bit_cnt <= boundary ? '0 : bit_cnt + BIT_W'(1);
          if (boundary) begin
            if (is_comma) begin
              bc_cnt <= bc_cnt + BC_W'(1);
              if (bc_cnt + BC_W'(1) == BC_DONE) begin
                state  <= ACTIVE;
                active <= 1'b1;
              end
            end else begin
              state  <= SEARCH;
              bc_cnt <= '0;
            end
          end
        end
        ACTIVE: begin
          bit_cnt <= boundary ? '0 : bit_cnt + BIT_W'(1);
          if (boundary && !is_comma) begin
            wr_vld_p1 <= 1'b1;
          end
        end
        default: begin
          state  <= SEARCH;
          active <= 1'b0;
        end
      endcase
    end
  end

  // ---- stage p1: completed word held one cycle before entering the FIFO ----
  // Word capture at each boundary; qualified downstream by wr_vld_p1.
  always_ff @(posedge clk) begin
    if (boundary) begin
      wr_data_p1 <= word_nxt;
    end
  end

  assign rd_en = read && !empty;
  assign full  = (count == FULL_CNT);
  // A full FIFO still accepts a write when a pop frees a slot on the same edge.
  assign wr_en = wr_vld_p1 && (!full || rd_en);

  // Next occupancy, shared by the counter and the registered flags.
  always_comb begin
    count_nxt = count;
    if (wr_en && !rd_en) begin
      count_nxt = count + CNT_W'(1);
    end else if (!wr_en && rd_en) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  // FIFO control, status flags and popped-word output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      empty       <= 1'b1;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      valid_out   <= 1'b0;
      out         <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        out    <= mem[rd_ptr];
      end
      if (wr_vld_p1 && !wr_en) begin
        overflow <= 1'b1;
      end
      count       <= count_nxt;
      empty       <= (count_nxt == '0);
      almost_full <= (count_nxt >= AF_CNT);
      valid_out   <= rd_en;
    end
  end

  // Storage array; contents are meaningless once the pointers are reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data_p1;
    end
  end

endmodule

// File: rtl/serial_rx_fifo_n.sv
// Multi-lane serial receiver: LANES independent aligned lanes with
// per-lane FIFOs, outputs concatenated lane 0 in the low bits.
module serial_rx_fifo_n
  import serial_rx_pkg::*;
#(
  parameter int                LANES      = 2,
  parameter int                WORD_W     = 8,
  parameter int                DEPTH      = 4,
  parameter int                AF_THRESH  = 3,
  parameter logic [WORD_W-1:0] COMMA      = WORD_W'(DEFAULT_COMMA),
  parameter int                SYNC_COUNT = DEFAULT_SYNC_COUNT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [LANES-1:0]        in,
  input  logic [LANES-1:0]        read,
  output logic [LANES*WORD_W-1:0] out,
  output logic [LANES-1:0]        valid_out,
  output logic [LANES-1:0]        empty,
  output logic [LANES-1:0]        almost_full,
  output logic [LANES-1:0]        active,
  output logic [LANES-1:0]        overflow
);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    serial_lane_rx #(
      .WORD_W     (WORD_W),
      .DEPTH      (DEPTH),
      .AF_THRESH  (AF_THRESH),
      .COMMA      (COMMA),
      .SYNC_COUNT (SYNC_COUNT)
    ) u_lane (
      .clk         (clk),
      .reset       (reset),
      .in          (in[g]),
      .read        (read[g]),
      .out         (out[g*WORD_W +: WORD_W]),
      .valid_out   (valid_out[g]),
      .empty       (empty[g]),
      .almost_full (almost_full[g]),
      .active      (active[g]),
      .overflow    (overflow[g])
    );
  end

endmodule

// File: tb/tb_serial_rx_fifo_n.sv
// Bench for serial_rx_fifo_n: a background serialiser feeds each lane from
// a word queue (idle word when empty); expected FIFO output is scoreboarded.
module tb_serial_rx_fifo_n;

  localparam int LANES = 2;
  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic                 clk;
  logic                 reset;
  logic [LANES-1:0]     ser_in;
  logic [LANES-1:0]     rd;
  logic [LANES*W-1:0]   dout;
  logic [LANES-1:0]     valid_out;
  logic [LANES-1:0]     empty;
  logic [LANES-1:0]     almost_full;
  logic [LANES-1:0]     active;
  logic [LANES-1:0]     overflow;

  serial_rx_fifo_n #(
    .LANES      (LANES),
    .WORD_W     (W),
    .DEPTH      (DEPTH),
    .AF_THRESH  (3),
    .COMMA      (8'hBC),
    .SYNC_COUNT (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in          (ser_in),
    .read        (rd),
    .out         (dout),
    .valid_out   (valid_out),
    .empty       (empty),
    .almost_full (almost_full),
    .active      (active),
    .overflow    (overflow)
  );

  typedef struct {
    int         len;
    logic [7:0] w;
  } tx_item_t;

  tx_item_t   txq   [LANES][$];
  logic [7:0] exp_q [LANES][$];
  logic [7:0] idle_w [LANES];
  logic [7:0] cur_w  [LANES];
  int         bit_left [LANES];
  bit         from_q [LANES];
  int         words_sent [LANES];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serialiser: one bit per lane per cycle, changed on the falling edge.
  task automatic tx_engine();
    tx_item_t e;
    forever begin
      @(negedge clk);
      for (int l = 0; l < LANES; l++) begin
        if (bit_left[l] == 0) begin
          if (txq[l].size() > 0) begin
            e = txq[l].pop_front();
            cur_w[l]    = e.w;
            bit_left[l] = e.len;
            from_q[l]   = 1'b1;
          end else begin
            cur_w[l]    = idle_w[l];
            bit_left[l] = 8;
            from_q[l]   = 1'b0;
          end
        end
        ser_in[l]   = cur_w[l][bit_left[l]-1];
        bit_left[l] = bit_left[l] - 1;
        if (bit_left[l] == 0 && from_q[l]) words_sent[l]++;
      end
    end
  endtask

  task automatic push_word(input int l, input logic [7:0] w, input bit expect_out);
    tx_item_t e;
    e.len = 8;
    e.w   = w;
    txq[l].push_back(e);
    if (expect_out) exp_q[l].push_back(w);
  endtask

  task automatic push_bits(input int l, input int len, input logic [7:0] w);
    tx_item_t e;
    e.len = len;
    e.w   = w;
    txq[l].push_back(e);
  endtask

  // Returns just after the rising edge that samples the last bit of word 'target'.
  task automatic wait_words(input int l, input int target);
    int n;
    n = 0;
    while (words_sent[l] < target && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (words_sent[l] < target) begin
      checks++;
      errors++;
      $display("FAIL wait_words lane %0d: sent %0d, needed %0d within 400 cycles",
               l, words_sent[l], target);
    end
  endtask

  // One-cycle pop, scored against the front of the lane's expected queue.
  task automatic read_one(input int l);
    logic [7:0] e;
    @(negedge clk);
    rd[l] = 1'b1;
    @(negedge clk);
    rd[l] = 1'b0;
    checks++;
    if (exp_q[l].size() == 0) begin
      errors++;
      $display("FAIL pop lane %0d: nothing expected but a read was issued", l);
    end else begin
      e = exp_q[l].pop_front();
      if (valid_out[l] !== 1'b1 || dout[l*W +: W] !== e) begin
        errors++;
        $display("FAIL pop lane %0d: got valid=%b data=%h, want valid=1 data=%h",
                 l, valid_out[l], dout[l*W +: W], e);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      txq[l].delete();
      exp_q[l].delete();
      idle_w[l] = 8'h00;
    end
    rd = '0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    int bad;
    idle_w[0] = 8'h55;
    idle_w[1] = 8'h55;
    reset = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (dout !== '0 || valid_out !== 2'b00 || empty !== 2'b11 ||
        almost_full !== 2'b00 || active !== 2'b00 || overflow !== 2'b00) begin
      errors++;
      $display("FAIL reset_values: out=%h valid=%b empty=%b af=%b active=%b ovf=%b, want 0000 00 11 00 00 00",
               dout, valid_out, empty, almost_full, active, overflow);
    end
    reset = 1'b1;
    bad = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      checks++;
      if (active !== 2'b00 || empty !== 2'b11) begin
        errors++;
        bad++;
        if (bad < 4)
          $display("FAIL no_sync_55 cycle %0d: active=%b empty=%b, want 00 11", c, active, empty);
      end
    end
    checks++;
    if (dout !== '0 || valid_out !== 2'b00 || overflow !== 2'b00 || almost_full !== 2'b00) begin
      errors++;
      $display("FAIL idle_outputs: out=%h valid=%b ovf=%b af=%b, want 0000 00 00 00",
               dout, valid_out, overflow, almost_full);
    end
  endtask

  task automatic test_lane_sync();
    int base;
    do_reset();
    base = words_sent[0];
    for (int i = 0; i < 4; i++) push_word(0, 8'hBC, 1'b0);
    push_word(0, 8'hFF, 1'b1);
    push_word(0, 8'hDD, 1'b1);
    idle_w[0] = 8'hBC;
    wait_words(0, base + 3);
    @(negedge clk);
    checks++;
    if (active !== 2'b00) begin
      errors++;
      $display("FAIL sync_after_3bc: active=%b, want 00", active);
    end
    wait_words(0, base + 4);
    @(negedge clk);
    checks++;
    if (active !== 2'b01) begin
      errors++;
      $display("FAIL sync_after_4bc: active=%b, want 01", active);
    end
    wait_words(0, base + 6);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (empty !== 2'b10) begin
      errors++;
      $display("FAIL lane_data_stored: empty=%b, want 10", empty);
    end
    read_one(0);
    read_one(0);
    @(negedge clk);
    checks++;
    if (valid_out !== 2'b00 || empty !== 2'b11) begin
      errors++;
      $display("FAIL lane_drained: valid=%b empty=%b, want 00 11", valid_out, empty);
    end
  endtask

  task automatic test_comma_offset();
    int base;
    do_reset();
    base = words_sent[0];
    push_bits(0, 3, 8'h00);
    for (int i = 0; i < 3; i++) push_word(0, 8'hBC, 1'b0);
    push_word(0, 8'h55, 1'b0);
    for (int i = 0; i < 4; i++) push_word(0, 8'hBC, 1'b0);
    idle_w[0] = 8'hBC;
    wait_words(0, base + 5);
    @(negedge clk);
    checks++;
    if (active[0] !== 1'b0) begin
      errors++;
      $display("FAIL offset_break: active=%b, want 0", active[0]);
    end
    wait_words(0, base + 8);
    @(negedge clk);
    checks++;
    if (active[0] !== 1'b0) begin
      errors++;
      $display("FAIL offset_resync_early: active=%b after 3 new commas, want 0", active[0]);
    end
    wait_words(0, base + 9);
    @(negedge clk);
    checks++;
    if (active !== 2'b01) begin
      errors++;
      $display("FAIL offset_resync: active=%b, want 01", active);
    end
  endtask

  task automatic test_overflow();
    int base;
    do_reset();
    base = words_sent[0];
    for (int i = 0; i < 4; i++) push_word(0, 8'hBC, 1'b0);
    push_word(0, 8'h11, 1'b1);
    push_word(0, 8'h22, 1'b1);
    push_word(0, 8'h33, 1'b1);
    push_word(0, 8'h44, 1'b1);
    push_word(0, 8'h55, 1'b0);
    idle_w[0] = 8'hBC;
    wait_words(0, base + 6);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (almost_full[0] !== 1'b0) begin
      errors++;
      $display("FAIL af_at_2: almost_full=%b, want 0", almost_full[0]);
    end
    wait_words(0, base + 7);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (almost_full[0] !== 1'b1) begin
      errors++;
      $display("FAIL af_at_3: almost_full=%b, want 1", almost_full[0]);
    end
    wait_words(0, base + 8);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (overflow[0] !== 1'b0) begin
      errors++;
      $display("FAIL ovf_at_full: overflow=%b, want 0", overflow[0]);
    end
    wait_words(0, base + 9);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (overflow !== 2'b01 || almost_full[0] !== 1'b1 || empty[0] !== 1'b0) begin
      errors++;
      $display("FAIL ovf_drop: overflow=%b af=%b empty=%b, want 01 1 0",
               overflow, almost_full[0], empty[0]);
    end
    for (int i = 0; i < 4; i++) read_one(0);
    @(negedge clk);
    checks++;
    if (empty[0] !== 1'b1 || overflow[0] !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drained: empty=%b overflow=%b, want 1 1", empty[0], overflow[0]);
    end
    rd[0] = 1'b1;
    @(negedge clk);
    rd[0] = 1'b0;
    checks++;
    if (valid_out[0] !== 1'b0 || dout[7:0] !== 8'h44) begin
      errors++;
      $display("FAIL read_empty: valid=%b out=%h, want 0 44", valid_out[0], dout[7:0]);
    end
  endtask

  task automatic test_full_rw();
    int base;
    do_reset();
    base = words_sent[0];
    for (int i = 0; i < 4; i++) push_word(0, 8'hBC, 1'b0);
    push_word(0, 8'h11, 1'b1);
    push_word(0, 8'h22, 1'b1);
    push_word(0, 8'h33, 1'b1);
    push_word(0, 8'h44, 1'b1);
    push_word(0, 8'h55, 1'b1);
    idle_w[0] = 8'hBC;
    wait_words(0, base + 8);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (almost_full[0] !== 1'b1 || empty[0] !== 1'b0) begin
      errors++;
      $display("FAIL full_before_rw: af=%b empty=%b, want 1 0", almost_full[0], empty[0]);
    end
    wait_words(0, base + 9);
    read_one(0);
    checks++;
    if (overflow[0] !== 1'b0 || almost_full[0] !== 1'b1) begin
      errors++;
      $display("FAIL full_rw: overflow=%b af=%b, want 0 1", overflow[0], almost_full[0]);
    end
    for (int i = 0; i < 4; i++) read_one(0);
    @(negedge clk);
    checks++;
    if (empty[0] !== 1'b1 || overflow[0] !== 1'b0) begin
      errors++;
      $display("FAIL full_rw_drained: empty=%b overflow=%b, want 1 0", empty[0], overflow[0]);
    end
  endtask

  task automatic test_async_reset();
    int base;
    do_reset();
    base = words_sent[0];
    for (int i = 0; i < 4; i++) push_word(0, 8'hBC, 1'b0);
    push_word(0, 8'h11, 1'b1);
    push_word(0, 8'h22, 1'b0);
    push_word(0, 8'h33, 1'b0);
    idle_w[0] = 8'hBC;
    wait_words(0, base + 7);
    @(posedge clk);
    @(negedge clk);
    read_one(0);
    checks++;
    if (empty[0] !== 1'b0 || active[0] !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_state: empty=%b active=%b, want 0 1", empty[0], active[0]);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (empty !== 2'b11 || active !== 2'b00 || overflow !== 2'b00 ||
        dout !== '0 || valid_out !== 2'b00 || almost_full !== 2'b00) begin
      errors++;
      $display("FAIL async_reset: empty=%b active=%b ovf=%b out=%h valid=%b af=%b, want 11 00 00 0000 00 00",
               empty, active, overflow, dout, valid_out, almost_full);
    end
    do_reset();
  endtask

  initial begin
    reset = 1'b0;
    rd    = '0;
    ser_in = '0;
    for (int l = 0; l < LANES; l++) begin
      idle_w[l]     = 8'h00;
      cur_w[l]      = 8'h00;
      bit_left[l]   = 0;
      from_q[l]     = 1'b0;
      words_sent[l] = 0;
    end
    fork
      tx_engine();
    join_none
    test_reset();
    test_lane_sync();
    test_comma_offset();
    test_overflow();
    test_full_rw();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
